mem_arb_ctrl: RTL and testbench



---
 rtl/mem_arb_ctrl_if.sv | 37 +++
 rtl/mem_arb_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mem_arb_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_ctrl_if.sv
// Requester, status and memory-pin bundle for mem_arb_ctrl.
// master: requesters plus the memory's read-data return; slave: the controller.
interface mem_arb_ctrl_if #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8
);
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        we;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*DATA_W-1:0] wdata;
  logic                   clr;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rvalid;
  logic [DATA_W-1:0]      rdata;
  logic                   clr_done;
  logic                   busy;
  logic                   mem_cen;
  logic                   mem_rd;
  logic                   mem_wr;
  logic                   mem_rst;
  logic [ADDR_W-1:0]      mem_add;
  logic [DATA_W-1:0]      mem_din;
  logic [DATA_W-1:0]      mem_dout;

  modport master (
    output req, we, addr, wdata, clr, mem_dout,
    input  gnt, rvalid, rdata, clr_done, busy,
    input  mem_cen, mem_rd, mem_wr, mem_rst, mem_add, mem_din
  );

  modport slave (
    input  req, we, addr, wdata, clr, mem_dout,
    output gnt, rvalid, rdata, clr_done, busy,
    output mem_cen, mem_rd, mem_wr, mem_rst, mem_add, mem_din
  );
endinterface

// File: rtl/mem_arb_ctrl.sv
// Round-robin arbiter and sequencer sharing one memory between NREQ requesters.
// One operation in flight at a time; every output is a flop fed from the next state.
module mem_arb_ctrl #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 2
) (
  input logic           clk,
  input logic           rst,
  mem_arb_ctrl_if.slave bus
);
  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = 3;

  typedef enum logic [1:0] {StIdle, StClear, StIssue, StWait} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   last_q, last_d, idx_q, idx_d, win, cand;
  logic              win_valid;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0]   gnt_q, gnt_d, rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, mem_din_q, mem_din_d;
  logic [ADDR_W-1:0] mem_add_q, mem_add_d;
  logic              clr_done_q, clr_done_d, busy_q, busy_d;
  logic              mem_cen_q, mem_cen_d, mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d, mem_rst_q, mem_rst_d;

  // Round-robin pick: first requester with req set, scanning from last+1.
  always_comb begin
    win       = last_q;
    win_valid = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IdxW'((32'(last_q) + k) % NREQ);
      if (!win_valid && bus.req[cand]) begin
        win       = cand;
        win_valid = 1'b1;
      end
    end
  end

  // Next state, latched request fields, and registered outputs derived from the next state.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    idx_d      = idx_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    rvalid_d   = '0;
    gnt_d      = '0;
    clr_done_d = 1'b0;
    mem_cen_d  = 1'b1;
    mem_rd_d   = 1'b0;
    mem_wr_d   = 1'b0;
    mem_rst_d  = 1'b0;
    mem_add_d  = '0;
    mem_din_d  = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.clr) begin
          state_d = StClear;
        end else if (win_valid) begin
          state_d = StIssue;
          last_d  = win;
          idx_d   = win;
          we_d    = bus.we[win];
          addr_d  = bus.addr[win*ADDR_W +: ADDR_W];
          wdata_d = bus.wdata[win*DATA_W +: DATA_W];
        end
      end
      StClear: state_d = StIdle;
      StIssue: begin
        if (we_q) begin
          state_d = StIdle;
        end else begin
          state_d = StWait;
          cnt_d   = CntW'(RD_LAT);
        end
      end
      StWait: begin
        cnt_d = cnt_q - CntW'(1);
        // Last wait cycle: mem_dout is valid now, so capture it and flag rvalid next cycle.
        if (cnt_q == CntW'(1)) begin
          state_d         = StIdle;
          rdata_d         = bus.mem_dout;
          rvalid_d[idx_q] = 1'b1;
        end
      end
    endcase

    unique case (state_d)
      StClear: begin
        mem_rst_d  = 1'b1;
        clr_done_d = 1'b1;
      end
      StIssue: begin
        gnt_d[idx_d] = 1'b1;
        mem_cen_d    = 1'b0;
        mem_add_d    = addr_d;
        mem_din_d    = wdata_d;
        mem_wr_d     = we_d;
        mem_rd_d     = !we_d;
      end
      StWait: begin
        mem_cen_d = 1'b0;
        mem_add_d = addr_d;
      end
      default: ;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State, latched request and output registers; synchronous reset drops any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      last_q     <= IdxW'(NREQ - 1);
      idx_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      clr_done_q <= 1'b0;
      busy_q     <= 1'b0;
      mem_cen_q  <= 1'b1;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_rst_q  <= 1'b0;
      mem_add_q  <= '0;
      mem_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      clr_done_q <= clr_done_d;
      busy_q     <= busy_d;
      mem_cen_q  <= mem_cen_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      mem_rst_q  <= mem_rst_d;
      mem_add_q  <= mem_add_d;
      mem_din_q  <= mem_din_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = rdata_q;
  assign bus.clr_done = clr_done_q;
  assign bus.busy     = busy_q;
  assign bus.mem_cen  = mem_cen_q;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_wr   = mem_wr_q;
  assign bus.mem_rst  = mem_rst_q;
  assign bus.mem_add  = mem_add_q;
  assign bus.mem_din  = mem_din_q;
endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Bench for mem_arb_ctrl: behavioural memory, event scoreboard, per-scenario tasks.
module tb_mem_arb_ctrl;
  localparam int unsigned NREQ   = 3;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned RD_LAT = 2;

  localparam int EvGnt = 0;
  localparam int EvRd  = 1;
  localparam int EvClr = 2;

  typedef struct {
    int         kind;
    int         idx;
    logic       wr;
    logic [11:0] add;
    logic [7:0] dat;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  ev_t  exp_q[$];
  ev_t  mon_ev;
  logic [31:0] got_v, exp_v;
  logic [2:0]  oh;

  mem_arb_ctrl_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arb_ctrl #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural 4 x 1024 x 8 memory; read data appears RD_LAT cycles after the issue cycle.
  logic [7:0] mem [0:4095];
  logic [7:0] rd_pipe [0:RD_LAT-1];
  always @(posedge clk) begin
    if (bus.mem_rst) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (!bus.mem_cen && bus.mem_wr) begin
      mem[bus.mem_add] <= bus.mem_din;
    end
    rd_pipe[0] <= (!bus.mem_cen && bus.mem_rd) ? mem[bus.mem_add] : 8'hEE;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_dout = rd_pipe[RD_LAT-1];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic void push(input int kind, input int idx, input logic wr,
                               input logic [11:0] add, input logic [7:0] dat);
    ev_t e;
    e.kind = kind;
    e.idx  = idx;
    e.wr   = wr;
    e.add  = add;
    e.dat  = dat;
    exp_q.push_back(e);
  endfunction

  task automatic drive(input int i, input logic w, input logic [11:0] a, input logic [7:0] d);
    bus.we[i]                       = w;
    bus.addr[i*ADDR_W +: ADDR_W]    = a;
    bus.wdata[i*DATA_W +: DATA_W]   = d;
    bus.req[i]                      = 1'b1;
  endtask

  task automatic do_reset();
    bus.req = '0;
    bus.clr = 1'b0;
    rst     = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  // Tick until the requested event on requester idx; requester drops req once granted.
  task automatic wait_for(input int kind, input int idx, input int budget, output int n);
    bit seen;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < budget) begin
      tick();
      n++;
      if (bus.gnt[idx]) bus.req[idx] = 1'b0;
      case (kind)
        EvGnt:   seen = bus.gnt[idx];
        EvRd:    seen = bus.rvalid[idx];
        default: seen = bus.clr_done;
      endcase
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_k%0d_r%0d: event not seen, required within %0d cycles",
               kind, idx, budget);
    end
  endtask

  task automatic test_reset();
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.clr   = 1'b0;
    rst       = 1'b1;
    repeat (3) tick();
    n_tests++;
    if ({bus.mem_cen, bus.mem_rd, bus.mem_wr, bus.mem_rst} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_strobes: cen/rd/wr/rst=%b, required 1000",
               {bus.mem_cen, bus.mem_rd, bus.mem_wr, bus.mem_rst});
    end
    n_tests++;
    if ({bus.busy, bus.gnt, bus.rvalid, bus.clr_done} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_status: busy/gnt/rvalid/clr_done=%b, required 0",
               {bus.busy, bus.gnt, bus.rvalid, bus.clr_done});
    end
    n_tests++;
    if ({bus.rdata, bus.mem_add, bus.mem_din} !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_data: rdata/add/din=%h, required 0",
               {bus.rdata, bus.mem_add, bus.mem_din});
    end
    rst = 1'b0;
    repeat (2) tick();
    n_tests++;
    if ({bus.busy, bus.mem_cen} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_idle: busy/cen=%b, required 01", {bus.busy, bus.mem_cen});
    end
  endtask

  task automatic test_write_read();
    int n;
    do_reset();
    drive(0, 1'b1, 12'h805, 8'hA5);
    push(EvGnt, 0, 1'b1, 12'h805, 8'hA5);
    tick();
    n_tests++;
    if ({bus.gnt, bus.mem_wr, bus.busy} !== 5'b00111) begin
      n_fail++;
      $display("FAIL wr_gnt_cycle: gnt/wr/busy=%b, required 00111",
               {bus.gnt, bus.mem_wr, bus.busy});
    end
    bus.req[0] = 1'b0;
    tick();
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_back_idle: busy=%b, required 0", bus.busy);
    end
    drive(0, 1'b0, 12'h805, 8'h5A);
    push(EvGnt, 0, 1'b0, 12'h805, 8'h5A);
    push(EvRd, 0, 1'b0, 12'h000, 8'hA5);
    wait_for(EvRd, 0, 10, n);
    n_tests++;
    if (n != 4) begin
      n_fail++;
      $display("FAIL rd_latency: rvalid after %0d cycles, required 4", n);
    end
    tick();
    n_tests++;
    if (bus.rvalid !== 3'b000) begin
      n_fail++;
      $display("FAIL rd_pulse: rvalid=%b one cycle later, required 000", bus.rvalid);
    end
  endtask

  task automatic test_round_robin();
    int grants, t, last_t;
    logic [2:0] g;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.we[i]                     = 1'b1;
      bus.addr[i*ADDR_W +: ADDR_W]  = 12'(12'h100 + i);
      bus.wdata[i*DATA_W +: DATA_W] = 8'(8'h10 + i);
    end
    for (int k = 0; k < 6; k++) push(EvGnt, k % 3, 1'b1, 12'(12'h100 + k % 3), 8'(8'h10 + k % 3));
    grants = 0;
    t      = 0;
    last_t = -1;
    bus.req = 3'b111;
    while (grants < 6 && t < 40) begin
      tick();
      t++;
      g = bus.gnt;
      if (g != 3'b000) begin
        n_tests++;
        if (g !== 3'(3'b001 << (grants % 3))) begin
          n_fail++;
          $display("FAIL rr_order_%0d: gnt=%b, required %b", grants, g,
                   3'(3'b001 << (grants % 3)));
        end
        if (last_t >= 0) begin
          n_tests++;
          if (t - last_t != 2) begin
            n_fail++;
            $display("FAIL rr_spacing_%0d: %0d cycles between grants, required 2",
                     grants, t - last_t);
          end
        end
        last_t = t;
        grants++;
      end
      bus.req = (grants < 6) ? (3'b111 & ~g) : 3'b000;
    end
    bus.req = 3'b000;
    if (grants < 6) begin
      n_tests++;
      n_fail++;
      $display("FAIL rr_timeout: %0d grants, required 6", grants);
    end
    repeat (2) tick();
  endtask

  task automatic test_clear_priority();
    int n;
    do_reset();
    drive(0, 1'b1, 12'h000, 8'h33);
    push(EvGnt, 0, 1'b1, 12'h000, 8'h33);
    wait_for(EvGnt, 0, 5, n);
    tick();
    bus.clr = 1'b1;
    drive(1, 1'b0, 12'h000, 8'h77);
    push(EvClr, 0, 1'b0, 12'h000, 8'h00);
    push(EvGnt, 1, 1'b0, 12'h000, 8'h77);
    push(EvRd, 1, 1'b0, 12'h000, 8'h00);
    tick();
    bus.clr = 1'b0;
    n_tests++;
    if ({bus.clr_done, bus.mem_rst, bus.gnt} !== 5'b11000) begin
      n_fail++;
      $display("FAIL clr_first: clr_done/mem_rst/gnt=%b, required 11000",
               {bus.clr_done, bus.mem_rst, bus.gnt});
    end
    wait_for(EvGnt, 1, 6, n);
    n_tests++;
    if (n != 2) begin
      n_fail++;
      $display("FAIL clr_then_gnt: gnt1 %0d cycles after clear, required 2", n);
    end
    wait_for(EvRd, 1, 10, n);
    n_tests++;
    if (bus.rdata !== 8'h00 || n != 3) begin
      n_fail++;
      $display("FAIL clr_read: rdata=%h after %0d cycles, required 00 after 3", bus.rdata, n);
    end
  endtask

  task automatic test_clr_hold();
    int n;
    logic [5:0] pat;
    pat = '0;
    bus.clr = 1'b1;
    for (int k = 0; k < 3; k++) push(EvClr, 0, 1'b0, 12'h000, 8'h00);
    for (int t = 1; t <= 6; t++) begin
      tick();
      pat = {pat[4:0], bus.clr_done};
      if (t == 5) bus.clr = 1'b0;
    end
    n_tests++;
    if (pat !== 6'b101010) begin
      n_fail++;
      $display("FAIL clr_hold: clr_done pattern=%b, required 101010", pat);
    end
    // last is still 1 after the clears, so requester 2 beats requester 0.
    drive(0, 1'b1, 12'h010, 8'h01);
    drive(2, 1'b1, 12'hC20, 8'h02);
    push(EvGnt, 2, 1'b1, 12'hC20, 8'h02);
    wait_for(EvGnt, 2, 4, n);
    bus.req = 3'b000;
    n_tests++;
    if (n != 1) begin
      n_fail++;
      $display("FAIL clr_keeps_last: gnt2 after %0d cycles, required 1", n);
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_read();
    int n, stray;
    do_reset();
    drive(2, 1'b0, 12'h805, 8'h00);
    push(EvGnt, 2, 1'b0, 12'h805, 8'h00);
    wait_for(EvGnt, 2, 4, n);
    tick();
    n_tests++;
    if ({bus.busy, bus.mem_cen, bus.mem_rd} !== 3'b100) begin
      n_fail++;
      $display("FAIL mid_wait: busy/cen/rd=%b, required 100",
               {bus.busy, bus.mem_cen, bus.mem_rd});
    end
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    n_tests++;
    if ({bus.busy, bus.rvalid, bus.gnt, bus.mem_cen, bus.mem_add} !== {7'b0000001, 12'h000}) begin
      n_fail++;
      $display("FAIL mid_reset_state: busy/rvalid/gnt/cen/add=%b, required 0000001/0",
               {bus.busy, bus.rvalid, bus.gnt, bus.mem_cen, bus.mem_add});
    end
    stray = 0;
    repeat (4) begin
      tick();
      if (bus.rvalid !== 3'b000) stray++;
    end
    n_tests++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL mid_no_rvalid: %0d cycles with rvalid, required 0", stray);
    end
    drive(0, 1'b1, 12'h001, 8'h11);
    drive(1, 1'b1, 12'h401, 8'h22);
    drive(2, 1'b1, 12'h801, 8'h33);
    push(EvGnt, 0, 1'b1, 12'h001, 8'h11);
    wait_for(EvGnt, 0, 4, n);
    bus.req = 3'b000;
    n_tests++;
    if (n != 1) begin
      n_fail++;
      $display("FAIL mid_next_gnt0: gnt0 after %0d cycles, required 1", n);
    end
    repeat (3) tick();
  endtask

  initial begin
    fork
      // Scoreboard: every gnt/rvalid/clear event pops and checks the oldest expectation.
      forever begin
        @(negedge clk);
        if (|bus.gnt || |bus.rvalid || bus.clr_done || bus.mem_rst) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: gnt=%b rvalid=%b clr_done=%b mem_rst=%b, required none",
                     bus.gnt, bus.rvalid, bus.clr_done, bus.mem_rst);
          end else begin
            mon_ev = exp_q.pop_front();
            oh = '0;
            oh[mon_ev.idx] = 1'b1;
            case (mon_ev.kind)
              EvGnt: begin
                exp_v = 32'({oh, 1'b0, !mon_ev.wr, mon_ev.wr, 1'b0, 3'b000, 1'b0,
                             mon_ev.add, mon_ev.dat});
                got_v = 32'({bus.gnt, bus.mem_cen, bus.mem_rd, bus.mem_wr, bus.mem_rst,
                             bus.rvalid, bus.clr_done, bus.mem_add, bus.mem_din});
              end
              EvRd: begin
                exp_v = 32'({oh, 3'b000, 1'b0, mon_ev.dat});
                got_v = 32'({bus.rvalid, bus.gnt, bus.clr_done, bus.rdata});
              end
              default: begin
                exp_v = 32'({1'b1, 1'b1, 1'b1, 3'b000, 3'b000});
                got_v = 32'({bus.mem_rst, bus.clr_done, bus.mem_cen, bus.gnt, bus.rvalid});
              end
            endcase
            if (got_v !== exp_v) begin
              n_fail++;
              $display("FAIL sb_k%0d_r%0d: got %h, required %h", mon_ev.kind, mon_ev.idx,
                       got_v, exp_v);
            end
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
      end
    join_none

    test_reset();
    test_write_read();
    test_round_robin();
    test_clear_priority();
    test_clr_hold();
    test_reset_mid_read();

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
